proc_debug_tap: RTL

Parametrised N-channel debug capture unit placed between the processor core and the on-chip VIO/LED display. Watches a flattened bus of processor probe words, arms on request, fires on a masked-compare trigger on one chosen channel, snapshots every channel after a programmable post-trigger delay, and presents the live or frozen value of a selected channel, plus a low-byte display output.

---
 rtl/proc_dbg_pkg.sv | 22 ++
 rtl/proc_dbg_chan_mux.sv | 25 ++
 rtl/proc_debug_tap.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/proc_dbg_pkg.sv
// Shared definitions for the processor debug capture tap: state encodings,
// default widths and the channel-index width helper.
package proc_dbg_pkg;

   localparam int DEF_NUM_CH = 10;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_OUT_W  = 8;
   localparam int DEF_DLY_W  = 8;

   // Capture FSM encodings; these values appear directly on the state output
   typedef logic [1:0] dbgState_t;
   localparam dbgState_t ST_IDLE     = 2'd0;
   localparam dbgState_t ST_ARMED    = 2'd1;
   localparam dbgState_t ST_DELAY    = 2'd2;
   localparam dbgState_t ST_CAPTURED = 2'd3;

   // Channel index width, never narrower than one bit even for a single channel
   function automatic int chWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/proc_dbg_chan_mux.sv
// Picks one probe word out of a flattened channel bus.
// An index at or beyond NUM_CH yields an all-zero word.
module proc_dbg_chan_mux
   import proc_dbg_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CH_W   = chWidth(NUM_CH)
) (
   input  logic [NUM_CH*DATA_W-1:0] bus_i,
   input  logic [CH_W-1:0]          idx_i,
   output logic [DATA_W-1:0]        word_o
);

   // Scan every channel; unmatched (out-of-range) indices leave the zero default
   always_comb begin
      word_o = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (idx_i == CH_W'(k)) begin
            word_o = bus_i[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/proc_debug_tap.sv
// N-channel debug capture tap between the core and the VIO/LED display.
// Arms on request, fires on a masked compare of one channel, snapshots all
// channels after a programmable delay and shows a live or frozen channel.
// Optional feature macro: PROC_DBG_CHANGE_CNT_EN adds per-channel
// saturating change counters on the chg_cnt output.
module proc_debug_tap
   import proc_dbg_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int DLY_W  = DEF_DLY_W,
   localparam int CH_W  = chWidth(NUM_CH)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_CH*DATA_W-1:0] probe_in,
   input  logic [CH_W-1:0]          sel,
   input  logic                     arm,
   input  logic                     clear,
   input  logic [CH_W-1:0]          trig_ch,
   input  logic [DATA_W-1:0]        trig_val,
   input  logic [DATA_W-1:0]        trig_mask,
   input  logic [DLY_W-1:0]         post_dly,
   output logic [1:0]               state,
   output logic                     captured,
   output logic [DATA_W-1:0]        snap_out,
   output logic [OUT_W-1:0]         led_out,
   output logic [31:0]              trig_cycle
`ifdef PROC_DBG_CHANGE_CNT_EN
   ,
   output logic [NUM_CH*16-1:0]     chg_cnt
`endif
);

   dbgState_t                state_q, state_d;
   logic [DLY_W-1:0]         dly_q, dly_d;
   logic [31:0]              cycleCnt_q;
   logic [31:0]              trigCycle_q, trigCycle_d;
   logic [NUM_CH*DATA_W-1:0] snap_q, snap_d;
   logic [DATA_W-1:0]        snapOut_q;
   logic [NUM_CH*DATA_W-1:0] srcBus;
   logic [DATA_W-1:0]        selWord;
   logic [DATA_W-1:0]        trigWord;
   logic                     trigMatch;

   // Display source: the frozen snapshot once captured, otherwise live probes
   assign srcBus = (state_q == ST_CAPTURED) ? snap_q : probe_in;

   proc_dbg_chan_mux #(
      .NUM_CH(NUM_CH),
      .DATA_W(DATA_W),
      .CH_W  (CH_W)
   ) u_selMux (
      .bus_i (srcBus),
      .idx_i (sel),
      .word_o(selWord)
   );

   proc_dbg_chan_mux #(
      .NUM_CH(NUM_CH),
      .DATA_W(DATA_W),
      .CH_W  (CH_W)
   ) u_trigMux (
      .bus_i (probe_in),
      .idx_i (trig_ch),
      .word_o(trigWord)
   );

   // Masked compare; compare settings are live, not latched at arm time
   assign trigMatch = (((trigWord ^ trig_val) & trig_mask) == '0);

   // Next-state logic; clear overrides everything and keeps capture results
   always_comb begin
      state_d     = state_q;
      dly_d       = dly_q;
      trigCycle_d = trigCycle_q;
      snap_d      = snap_q;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (trigMatch) begin
               trigCycle_d = cycleCnt_q;
               if (post_dly == '0) begin
                  snap_d  = probe_in;
                  state_d = ST_CAPTURED;
               end else begin
                  dly_d   = post_dly;
                  state_d = ST_DELAY;
               end
            end
         end
         ST_DELAY: begin
            // dly_q reaching one means this is exactly post_dly cycles after the match
            if (dly_q == DLY_W'(1)) begin
               snap_d  = probe_in;
               state_d = ST_CAPTURED;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         default: begin
         end
      endcase
      if (clear) begin
         state_d     = ST_IDLE;
         dly_d       = '0;
         trigCycle_d = trigCycle_q;
         snap_d      = snap_q;
      end
   end

   // State, delay, trigger timestamp, snapshot and registered display word
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dly_q       <= '0;
         cycleCnt_q  <= '0;
         trigCycle_q <= '0;
         snap_q      <= '0;
         snapOut_q   <= '0;
      end else begin
         state_q     <= state_d;
         dly_q       <= dly_d;
         cycleCnt_q  <= cycleCnt_q + 32'd1;
         trigCycle_q <= trigCycle_d;
         snap_q      <= snap_d;
         snapOut_q   <= selWord;
      end
   end

   assign state      = state_q;
   assign captured   = (state_q == ST_CAPTURED);
   assign snap_out   = snapOut_q;
   assign led_out    = snapOut_q[OUT_W-1:0];
   assign trig_cycle = trigCycle_q;

`ifdef PROC_DBG_CHANGE_CNT_EN
   logic [NUM_CH*DATA_W-1:0] prevProbe_q;
   logic [NUM_CH*16-1:0]     chgCnt_q;
   logic                     armAccept;
   logic                     countEn;

   assign armAccept = (state_q == ST_IDLE) && arm && !clear;
   assign countEn   = (state_q == ST_ARMED) || (state_q == ST_DELAY);

   // Per-channel saturating count of cycles whose probe differs from the previous cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         prevProbe_q <= '0;
         chgCnt_q    <= '0;
      end else begin
         prevProbe_q <= probe_in;
         for (int k = 0; k < NUM_CH; k++) begin
            if (armAccept) begin
               chgCnt_q[k*16 +: 16] <= '0;
            end else if (countEn &&
                         (probe_in[k*DATA_W +: DATA_W] != prevProbe_q[k*DATA_W +: DATA_W]) &&
                         (chgCnt_q[k*16 +: 16] != 16'hFFFF)) begin
               chgCnt_q[k*16 +: 16] <= chgCnt_q[k*16 +: 16] + 16'd1;
            end
         end
      end
   end

   assign chg_cnt = chgCnt_q;
`endif

endmodule
